// File: rtl/dma_ahb_fifo_pkg.sv
// Shared constants for the small synchronous DMA/AHB FIFO.
// Defaults for data width, address width and count width.
package dma_ahb_fifo_pkg;

  localparam int FDW_DEF = 32;
  localparam int FAW_DEF = 4;
  localparam int CNT_W   = FAW_DEF + 1;

  function automatic int depth_of(input int faw);
    return 1 << faw;
  endfunction

endpackage

// File: rtl/dma_ahb_fifo_sync_small_if.sv
// Write/read handshake bundle of the small synchronous FIFO.
// master = producer/consumer side, slave = FIFO side.
interface dma_ahb_fifo_sync_small_if
  import dma_ahb_fifo_pkg::*;
#(
  parameter int FDW = FDW_DEF,
  parameter int FAW = FAW_DEF
);

  logic           clr;
  logic           wr_rdy;
  logic           wr_vld;
  logic [FDW-1:0] wr_din;
  logic           rd_rdy;
  logic           rd_vld;
  logic [FDW-1:0] rd_dout;
  logic           full;
  logic           empty;
  logic           fullN;
  logic           emptyN;
  logic [FAW:0]   rd_cnt;
  logic [FAW:0]   wr_cnt;

  modport master (
    output clr, wr_vld, wr_din, rd_rdy,
    input  wr_rdy, rd_vld, rd_dout,
    input  full, empty, fullN, emptyN,
    input  rd_cnt, wr_cnt
  );

  modport slave (
    input  clr, wr_vld, wr_din, rd_rdy,
    output wr_rdy, rd_vld, rd_dout,
    output full, empty, fullN, emptyN,
    output rd_cnt, wr_cnt
  );

endinterface

// File: rtl/dma_ahb_fifo_ram.sv
// FIFO storage: one synchronous write port, one async read port.
// Contents are not reset; validity is tracked by the pointers.
module dma_ahb_fifo_ram
  import dma_ahb_fifo_pkg::*;
#(
  parameter int FDW = FDW_DEF,
  parameter int FAW = FAW_DEF
) (
  input  logic           clk,
  input  logic           we_i,
  input  logic [FAW-1:0] waddr_i,
  input  logic [FDW-1:0] wdata_i,
  input  logic [FAW-1:0] raddr_i,
  output logic [FDW-1:0] rdata_o
);

  logic [FDW-1:0] mem_q [depth_of(FAW)];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dma_ahb_fifo_sync_small.sv
// Small first-word-fall-through synchronous FIFO, 2**FAW x FDW.
// Define DMA_AHB_FIFO_CHECK_EN for sim-only overflow/underflow errors.
module dma_ahb_fifo_sync_small
  import dma_ahb_fifo_pkg::*;
#(
  parameter int FDW = FDW_DEF,
  parameter int FAW = FAW_DEF
) (
  input logic clk,
  input logic rst,
  dma_ahb_fifo_sync_small_if.slave f
);

  localparam int CW    = FAW + 1;
  localparam int DEPTH = depth_of(FAW);

  logic [CW-1:0] wp_q, wp_d;
  logic [CW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt;
  logic          full, empty;
  logic          push, pop;

  // Extra MSB on each pointer tells full from empty.
  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[FAW] != rp_q[FAW]) &&
                 (wp_q[FAW-1:0] == rp_q[FAW-1:0]);
  assign cnt   = wp_q - rp_q;

  assign push = f.wr_vld & ~full;
  assign pop  = f.rd_rdy & ~empty;

  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    if (f.clr) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (push) wp_d = wp_q + CW'(1);
      if (pop)  rp_d = rp_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  dma_ahb_fifo_ram #(
    .FDW (FDW),
    .FAW (FAW)
  ) u_ram (
    .clk     (clk),
    .we_i    (push & ~f.clr & ~rst),
    .waddr_i (wp_q[FAW-1:0]),
    .wdata_i (f.wr_din),
    .raddr_i (rp_q[FAW-1:0]),
    .rdata_o (f.rd_dout)
  );

  assign f.full   = full;
  assign f.empty  = empty;
  assign f.wr_rdy = ~full;
  assign f.rd_vld = ~empty;
  assign f.fullN  = (cnt == CW'(DEPTH - 1));
  assign f.emptyN = (cnt == CW'(1));
  assign f.rd_cnt = cnt;
  assign f.wr_cnt = CW'(DEPTH) - cnt;

`ifdef DMA_AHB_FIFO_CHECK_EN
  always @(posedge clk) begin
    if (!rst && f.wr_vld && full)
      $error("%0t: push while full", $time);
    if (!rst && f.rd_rdy && empty)
      $error("%0t: pop while empty", $time);
  end
`else
`endif

endmodule

// File: tb/tb_dma_ahb_fifo_sync_small.sv
// Self-checking bench for dma_ahb_fifo_sync_small.
// Reference is a plain queue updated by the FIFO's rules.
module tb_dma_ahb_fifo_sync_small;
  import dma_ahb_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  dma_ahb_fifo_sync_small_if #(.FDW(32), .FAW(4)) bus ();

  dma_ahb_fifo_sync_small #(
    .FDW (32),
    .FAW (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .f   (bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("empty",  64'(bus.empty),  64'(n == 0));
    chk("full",   64'(bus.full),   64'(n == 16));
    chk("rd_vld", 64'(bus.rd_vld), 64'(n != 0));
    chk("wr_rdy", 64'(bus.wr_rdy), 64'(n != 16));
    chk("fullN",  64'(bus.fullN),  64'(n == 15));
    chk("emptyN", 64'(bus.emptyN), 64'(n == 1));
    chk("rd_cnt", 64'(bus.rd_cnt), 64'(n));
    chk("wr_cnt", 64'(bus.wr_cnt), 64'(16 - n));
    if (n != 0)
      chk("rd_dout", 64'(bus.rd_dout), 64'(q[0]));
  endtask

  task automatic cyc(input logic wv, input logic [31:0] d,
                     input logic rr, input logic c,
                     input logic r);
    bit pu, po;
    bus.wr_vld = wv;
    bus.wr_din = d;
    bus.rd_rdy = rr;
    bus.clr    = c;
    rst        = r;
    pu = wv && (q.size() < 16);
    po = rr && (q.size() > 0);
    @(posedge clk);
    #1;
    if (r || c) begin
      q.delete();
    end else begin
      if (po) void'(q.pop_front());
      if (pu) q.push_back(d);
    end
    check_all();
  endtask

  initial begin
    logic [31:0] d;
    bus.wr_vld = 1'b0;
    bus.wr_din = '0;
    bus.rd_rdy = 1'b0;
    bus.clr    = 1'b0;

    // reset state
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("rst_empty",  64'(bus.empty),  64'd1);
    chk("rst_wr_rdy", 64'(bus.wr_rdy), 64'd1);
    chk("rst_rd_cnt", 64'(bus.rd_cnt), 64'd0);
    chk("rst_wr_cnt", 64'(bus.wr_cnt), 64'd16);

    // single word, fall-through, then pop
    cyc(1, 32'hA5A5_0001, 0, 0, 0);
    chk("one_vld",    64'(bus.rd_vld),  64'd1);
    chk("one_dout",   64'(bus.rd_dout), 64'hA5A5_0001);
    chk("one_emptyN", 64'(bus.emptyN),  64'd1);
    cyc(0, 0, 1, 0, 0);
    chk("one_popped", 64'(bus.empty), 64'd1);

    // fill to full, overflow attempt, drain in order
    for (int i = 0; i < 16; i++) begin
      cyc(1, 32'(i), 0, 0, 0);
      if (i == 14) chk("fullN15", 64'(bus.fullN), 64'd1);
    end
    chk("full16",   64'(bus.full),   64'd1);
    chk("wrrdy16",  64'(bus.wr_rdy), 64'd0);
    cyc(1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("ovf_cnt",  64'(bus.rd_cnt), 64'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain", 64'(bus.rd_dout), 64'(i));
      cyc(0, 0, 1, 0, 0);
    end
    cyc(0, 0, 1, 0, 0);
    chk("udf_cnt", 64'(bus.rd_cnt), 64'd0);

    // steady state at count 8, pointers wrap
    for (int i = 0; i < 8; i++) cyc(1, $urandom, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, $urandom, 1, 0, 0);
      chk("ss_cnt", 64'(bus.rd_cnt), 64'd8);
    end

    // clear overrides push
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, $urandom, 0, 0, 0);
    cyc(1, $urandom, 0, 1, 0);
    chk("clr_empty", 64'(bus.empty),  64'd1);
    chk("clr_cnt",   64'(bus.rd_cnt), 64'd0);

    // reset mid-operation
    for (int i = 0; i < 8; i++) cyc(1, $urandom, 0, 0, 0);
    cyc(1, $urandom, 1, 0, 1);
    chk("rst2_empty",  64'(bus.empty),  64'd1);
    chk("rst2_wr_cnt", 64'(bus.wr_cnt), 64'd16);
    chk("rst2_fullN",  64'(bus.fullN),  64'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      d = $urandom;
      cyc(1'($urandom_range(0, 99) < 60), d,
          1'($urandom_range(0, 99) < 50),
          1'($urandom_range(0, 99) < 2),
          1'($urandom_range(0, 99) < 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_ahb_fifo_sync_small.md
DMA_AHB_FIFO_SYNC_SMALL -- requirements
Module: dma_ahb_fifo_sync_small

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter FDW, default 32, SHALL set the data width in bits.
REQ-003 Parameter FAW, default 4, SHALL set the address width; depth is 2**FAW (16).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-006 clr  input  1  SHALL be a synchronous, active-high clear that empties the FIFO.
REQ-007 wr_rdy  output  1  SHALL mean "FIFO can accept a word" (equals not full).
REQ-008 wr_vld  input  1  SHALL be write-request valid.
REQ-009 wr_din  input  FDW  SHALL be write data.
REQ-010 rd_rdy  input  1  SHALL be the consumer-ready (pop) request.
REQ-011 rd_vld  output  1  SHALL mean "head word valid" (equals not empty).
REQ-012 rd_dout  output  FDW  SHALL show the head word combinationally (first-word fall-through).
REQ-013 full / empty  output  1 each  SHALL be asserted when count==2**FAW / count==0.
REQ-014 fullN  output  1  SHALL be lookahead full: count==2**FAW-1.
REQ-015 emptyN  output  1  SHALL be lookahead empty: count==1.
REQ-016 rd_cnt  output  FAW+1  SHALL be the number of stored words.
REQ-017 wr_cnt  output  FAW+1  SHALL be the number of free slots (2**FAW - rd_cnt).

Function
REQ-018 A push SHALL occur when wr_vld & wr_rdy; wr_din is stored at the write pointer.
REQ-019 A pop SHALL occur when rd_rdy & rd_vld; the read pointer advances and the next word appears on rd_dout in the following cycle.
REQ-020 A write to an empty FIFO SHALL make rd_vld high one cycle later; no same-cycle bypass.
REQ-021 A push when full SHALL be ignored; a pop when empty SHALL be ignored; count and data are unchanged.
REQ-022 Simultaneous push and pop SHALL leave count unchanged and advance both pointers; when full, only the pop occurs (wr_rdy low).
REQ-023 Pointers SHALL be FAW+1 bits and wrap modulo 2**(FAW+1); full = MSBs differ and lower bits equal; empty = pointers equal.
REQ-024 rd_dout SHALL be don't-care while rd_vld is low.
REQ-025 clr SHALL reset both pointers to 0 on the next edge, overriding any same-cycle push or pop; stored data need not be cleared.

Reset
REQ-026 While rst is high, at the clock edge, pointers SHALL go to 0: empty=1, full=0, rd_vld=0, wr_rdy=1, fullN=0, emptyN=0, rd_cnt=0, wr_cnt=2**FAW.
REQ-027 rst SHALL take priority over clr, wr_vld and rd_rdy; reset mid-operation discards all contents.

Configuration
REQ-028 Macro DMA_AHB_FIFO_CHECK_EN defined: simulation-only checks SHALL print an error with $time on push-while-full and pop-while-empty; behaviour otherwise identical.
REQ-029 Macro undefined: no checks SHALL be compiled; logic unchanged.

Structure
REQ-030 Package dma_ahb_fifo_pkg SHALL hold the default FDW/FAW constants and the count-width constant (FAW+1).
REQ-031 Storage SHALL be one sub-module, dma_ahb_fifo_ram (1 write port, 1 asynchronous read port, 2**FAW x FDW).

Verification
REQ-032 After rst: empty=1, wr_rdy=1, rd_cnt=0, wr_cnt=16.
REQ-033 Push 0xA5A5_0001 into empty FIFO: next cycle rd_vld=1, rd_dout=0xA5A5_0001, emptyN=1; pop -> empty=1.
REQ-034 Push 16 words 0..15: after 15, fullN=1; after 16, full=1, wr_rdy=0; a 17th push is ignored; 16 pops return 0..15 in order.
REQ-035 With count=8, push and pop together for 20 cycles: rd_cnt stays 8, data in order, pointers wrap correctly.
REQ-036 Fill with 5 words, assert clr with wr_vld=1: next cycle empty=1, rd_cnt=0.
REQ-037 Assert rst while half full and rd_rdy=1: all outputs return to reset values on the next edge.
